hampel_detect: RTL

Downstream consumer of the MAD calculator: buffers raw samples in a FIFO and, on each median/MAD result, pops the oldest sample. It classifies that sample as an outlier when |x − median| > K·MAD, and replaces outliers with the rounded median. It sits between the MADcalc stage and the output sink, and tracks outlier statistics plus FIFO error flags.

---
 rtl/hampel_detect.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/hampel_detect.sv
// hampel_detect: Hampel outlier filter placed after the MAD calculator.
//
// Raw samples are buffered in a circular FIFO. Each median/MAD result pops the
// oldest sample. The sample is flagged as an outlier when |x - median| > K*MAD,
// and an outlier is replaced by the rounded median.
//
// Pipeline: pop + arithmetic (stage 1), compare + select (stage 2), output regs.
// A pop sampled at edge N shows data_out_vld after edge N+2.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   sample_in/_vld    raw sample stream, pushed into the FIFO
//   median_in, mad_in Q8.8 median and scaled MAD, qualified by mad_vld (pops)
//   data_out/_vld     filtered sample, one-cycle valid pulse
//   outlier           data_out is the replacement value
//   outlier_cnt       saturating count of outliers since reset
//   fifo_level        current FIFO occupancy
//   ovf_err, unf_err  sticky: push dropped while full / result while empty
module hampel_detect #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  K          = 8'h30,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_vld,
    input  logic [15:0]                   median_in,
    input  logic [15:0]                   mad_in,
    input  logic                          mad_vld,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_out_vld,
    output logic                          outlier,
    output logic [CNT_WIDTH-1:0]          outlier_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_err,
    output logic                          unf_err
);

    localparam int unsigned AddrWidth = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlWidth  = AddrWidth + 1;
    localparam logic [16:0] RepMax    = 17'((64'd1 << DATA_WIDTH) - 64'd1);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlWidth-1:0]   level_d;
    logic                  fifo_empty, fifo_full;
    logic                  pop_ok, push_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LvlWidth'(FIFO_DEPTH));
    assign pop_ok     = mad_vld && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push at full still succeeds.
    assign push_ok    = sample_vld && (!fifo_full || pop_ok);
    assign rd_data    = mem[rd_ptr_q];

    always_comb begin
        level_d = fifo_level;
        case ({push_ok, pop_ok})
            2'b10:   level_d = fifo_level + LvlWidth'(1);
            2'b01:   level_d = fifo_level - LvlWidth'(1);
            default: level_d = fifo_level;
        endcase
    end

    // Storage is not reset; contents are meaningless after reset anyway.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
            fifo_level <= level_d;
            if (sample_vld && fifo_full && !pop_ok) ovf_err <= 1'b1;
            if (mad_vld && fifo_empty)              unf_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 arithmetic (on the popped sample)
    // ------------------------------------------------------------------
    logic [15:0]           x_q88;
    logic [15:0]           dev;
    logic [23:0]           thr;
    logic [16:0]           rep_sum;
    logic [8:0]            rep_int;
    logic [DATA_WIDTH-1:0] rep;

    always_comb begin
        x_q88   = 16'({rd_data, 8'h00});
        dev     = (x_q88 >= median_in) ? (x_q88 - median_in) : (median_in - x_q88);
        thr     = 24'(K) * 24'(mad_in);
        // 17-bit add keeps the carry so 16'hFFC0 rounds up and saturates.
        rep_sum = {1'b0, median_in} + 17'h00080;
        rep_int = rep_sum[16:8];
        if ({8'h00, rep_int} > RepMax) begin
            rep = DATA_WIDTH'(RepMax);
        end else begin
            rep = DATA_WIDTH'(rep_int);
        end
    end

    logic                  s1_vld_q;
    logic [15:0]           s1_dev_q;
    logic [23:0]           s1_thr_q;
    logic [DATA_WIDTH-1:0] s1_rep_q;
    logic [DATA_WIDTH-1:0] s1_raw_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s1_dev_q <= '0;
            s1_thr_q <= '0;
            s1_rep_q <= '0;
            s1_raw_q <= '0;
        end else begin
            s1_vld_q <= pop_ok;
            if (pop_ok) begin
                s1_dev_q <= dev;
                s1_thr_q <= thr;
                s1_rep_q <= rep;
                s1_raw_q <= rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compare and select
    // ------------------------------------------------------------------
    logic                  is_outlier;
    logic                  s2_vld_q;
    logic                  s2_outlier_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    // dev is Q8.8, thr is Q12.12: align dev by 4 fractional bits.
    assign is_outlier = ({4'b0000, s1_dev_q, 4'b0000} > s1_thr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q     <= 1'b0;
            s2_outlier_q <= 1'b0;
            s2_data_q    <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_outlier_q <= is_outlier;
                s2_data_q    <= is_outlier ? s1_rep_q : s1_raw_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out     <= '0;
            data_out_vld <= 1'b0;
            outlier      <= 1'b0;
            outlier_cnt  <= '0;
        end else begin
            data_out_vld <= s2_vld_q;
            if (s2_vld_q) begin
                data_out <= s2_data_q;
                outlier  <= s2_outlier_q;
                if (s2_outlier_q && (outlier_cnt != '1)) begin
                    outlier_cnt <= outlier_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
